pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard, stall and flush controller for the 5-stage RV64 pipeline (IF, ID, EX, MEM, WB).
- Sequences the PC, IF/ID and ID/EX registers:
  - detects load-use hazards and inserts one bubble;
  - redirects and flushes on a taken branch resolved in EX;
  - drains the pipeline on a halt request and holds it halted until resumed.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- PIPE_DEPTH, 5, number of pipeline stages. The DRAIN phase lasts PIPE_DEPTH-1 cycles.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- if_id_rs1  in  5  rs1 field of the instruction in ID
- if_id_rs2  in  5  rs2 field of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_ex_rd  in  5  rd of the instruction in EX
- id_ex_mem_read  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch resolved taken in EX (branch & zero)
- halt_req  in  1  request to drain and halt, level-sampled
- resume  in  1  leave HALTED, single-cycle pulse
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID load enable (0 = hold)
- if_id_flush  out  1  load NOP into IF/ID at the next edge
- id_ex_bubble  out  1  zero all control fields loaded into ID/EX
- pc_sel  out  1  1 = next PC is branch_target, 0 = PC+4
- halted  out  1  pipeline drained and frozen
- state  out  2  current state: RUN=0, DRAIN=1, HALTED=2
- stall_cnt  out  CNT_W  count of load-use stall cycles
- flush_cnt  out  CNT_W  count of honored taken branches

Behaviour:

Reset
- On rst_n=0, immediately: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0.
- Outputs take RUN values:
  - with all inputs 0: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pc_sel=0, halted=0.
- Reset mid-DRAIN or mid-HALTED returns to RUN with no residue.

Output timing
- All control outputs are combinational from the state register and the current inputs (zero-cycle latency).
- State and counters update on the rising edge of clk.

Load-use hazard
- lu = id_ex_mem_read & (id_ex_rd != 0) & ((id_uses_rs1 & if_id_rs1 == id_ex_rd) | (id_uses_rs2 & if_id_rs2 == id_ex_rd)).

RUN state
- ex_branch_taken=1 (highest priority):
  - pc_sel=1, pc_write=1, if_id_flush=1, id_ex_bubble=1;
  - flush_cnt+1;
  - lu is ignored that cycle.
- Otherwise lu=1:
  - pc_write=0, if_id_write=0, id_ex_bubble=1;
  - stall_cnt+1.
  - Exactly one bubble per load: the next cycle the load is in MEM and lu clears.
- Otherwise: normal flow (pc_write=1, if_id_write=1).
- halt_req=1 while ex_branch_taken=0:
  - next state DRAIN, drain counter loaded with PIPE_DEPTH-1.
  - The current cycle still applies the lu rule.
- halt_req together with ex_branch_taken: the branch is honored, halt_req is re-sampled next cycle.

DRAIN state
- pc_write=0, if_id_write=0, id_ex_bubble=1. The ID instruction is held, not lost.
- Drain counter decrements each cycle. At counter==1, next state is HALTED.
- ex_branch_taken=1 in DRAIN (branch already in EX):
  - pc_sel=1, pc_write=1, if_id_flush=1;
  - flush_cnt+1;
  - the drain counter continues.
- lu is not counted in DRAIN.

HALTED state
- halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1.
- halt_req and ex_branch_taken are ignored.
- resume=1: next state RUN. resume is ignored in RUN and DRAIN.

Counters
- Saturate at 2^CNT_W-1 and never wrap.

Test Plan:
1. Reset: rst_n=0 asserted mid-cycle -> state=0, pc_write=1, if_id_write=1, stall_cnt=0, flush_cnt=0 without a clock edge.
2. Load-use: id_ex_mem_read=1, id_ex_rd=5, if_id_rs2=5, id_uses_rs2=1 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt=1 after the edge. Repeat with id_ex_rd=0 -> no stall.
3. Branch priority: ex_branch_taken=1 together with the item-2 load-use condition -> pc_sel=1, if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt=1, stall_cnt unchanged.
4. Halt drain: halt_req=1 at cycle T -> state=1 for cycles T+1..T+4, state=2 and halted=1 at T+5, pc_write=0 throughout. resume pulse at T+7 -> state=0 at T+8.
5. Branch during DRAIN: ex_branch_taken=1 in the first DRAIN cycle -> pc_sel=1, pc_write=1, if_id_flush=1; HALTED is still reached at T+5.
6. Saturation: CNT_W=2, force 5 consecutive load-use stalls -> stall_cnt reads 3 and holds at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
// The datapath (master) drives hazard observations; the controller (slave) returns enables.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       if_id_rs1;
    logic [4:0]       if_id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             ex_branch_taken;
    logic             halt_req;
    logic             resume;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pc_sel;
    logic             halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_mem_read, ex_branch_taken, halt_req, resume,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_sel,
               halted, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_uses_rs1, id_uses_rs2, id_ex_rd,
               id_ex_mem_read, ex_branch_taken, halt_req, resume,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pc_sel,
               halted, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage pipeline, with saturating
// load-use stall and taken-branch flush counters for performance debug.
module pipeline_hazard_ctrl #(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam int DRAIN_W = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 1);

    state_t             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               lu, stall_inc, flush_inc;

    assign lu = hz.id_ex_mem_read && (hz.id_ex_rd != 5'd0) &&
                ((hz.id_uses_rs1 && (hz.if_id_rs1 == hz.id_ex_rd)) ||
                 (hz.id_uses_rs2 && (hz.if_id_rs2 == hz.id_ex_rd)));

    // A taken branch outranks the load-use stall; in DRAIN a branch already in EX is still honored.
    assign stall_inc = (state_q == RUN) && !hz.ex_branch_taken && lu;
    assign flush_inc = ((state_q == RUN) || (state_q == DRAIN)) && hz.ex_branch_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: begin
                if (!hz.ex_branch_taken && hz.halt_req) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q == DRAIN_W'(1)) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (hz.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase
    end

    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_ex_bubble = 1'b0;
        hz.pc_sel       = 1'b0;
        hz.halted       = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.ex_branch_taken) begin
                    hz.pc_sel       = 1'b1;
                    hz.if_id_flush  = 1'b1;
                    hz.id_ex_bubble = 1'b1;
                end else if (lu) begin
                    hz.pc_write     = 1'b0;
                    hz.if_id_write  = 1'b0;
                    hz.id_ex_bubble = 1'b1;
                end
            end
            DRAIN: begin
                hz.pc_write     = hz.ex_branch_taken;
                hz.if_id_write  = 1'b0;
                hz.if_id_flush  = hz.ex_branch_taken;
                hz.id_ex_bubble = 1'b1;
                hz.pc_sel       = hz.ex_branch_taken;
            end
            HALTED: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
                hz.halted       = 1'b1;
            end
            default: begin
                hz.pc_write     = 1'b0;
                hz.if_id_write  = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
        endcase
    end

    // Counters stick at all-ones so a long run never reads back as a small count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.state     = state_q;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
endmodule
